// File: rtl/pkt_fifo.sv
// rtl/pkt_fifo.sv - packet FIFO exposing only committed packets to the reader
// Whole packets are dropped on overflow or framing error; partial packets never become readable.
module pkt_fifo #(
  parameter int data_width = 64,
  parameter int depth      = 512,
  parameter int ptr_width  = 9,
  parameter int prio_width = 3,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_vld,
  input  logic                  wr_sop,
  input  logic                  wr_eop,
  input  logic [data_width-1:0] wr_data,
  input  logic [prio_width-1:0] wr_prio,
  input  logic                  rd_en,
  output logic                  rd_vld,
  output logic                  rd_sop,
  output logic                  rd_eop,
  output logic [data_width-1:0] rd_data,
  output logic [prio_width-1:0] rd_prio,
  output logic [ptr_width:0]    pkt_cnt,
  output logic [ptr_width:0]    free_words,
  output logic                  overflow,
  output logic [cnt_width-1:0]  drop_cnt
);

  localparam int entry_width = data_width + prio_width + 2;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
  typedef logic [ptr_width:0] ptr_t;

  localparam ptr_t depth_p = ptr_t'(depth);

  state_t                  state_q, state_d;
  ptr_t                    rptr_q, rptr_d, cptr_q, cptr_d, wptr_q, wptr_d;
  logic [prio_width-1:0]   prio_q, prio_d;
  ptr_t                    pkt_cnt_q, pkt_cnt_d, free_q, free_d;
  logic                    overflow_q, overflow_d;
  logic [cnt_width-1:0]    drop_cnt_q, drop_cnt_d;
  logic [entry_width-1:0]  mem_q [depth];

  logic                    full, base_full, start, commit, we, rd_fire;
  logic [1:0]              drop_inc;
  logic [ptr_width-1:0]    waddr;
  logic [entry_width-1:0]  wentry, head;
  logic [cnt_width:0]      drop_sum;

  // Full checks use rptr before this cycle's read; freed space shows up next cycle.
  assign full      = (wptr_q - rptr_q) == depth_p;
  assign base_full = (cptr_q - rptr_q) == depth_p;

  assign head    = mem_q[rptr_q[ptr_width-1:0]];
  assign rd_vld  = rptr_q != cptr_q;
  assign rd_sop  = head[entry_width-1];
  assign rd_eop  = head[entry_width-2];
  assign rd_prio = head[data_width +: prio_width];
  assign rd_data = head[data_width-1:0];
  assign rd_fire = rd_en && rd_vld;

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    cptr_d     = cptr_q;
    prio_d     = prio_q;
    overflow_d = overflow_q;
    drop_inc   = 2'd0;
    commit     = 1'b0;
    start      = 1'b0;
    we         = 1'b0;
    waddr      = wptr_q[ptr_width-1:0];
    wentry     = {wr_sop, wr_eop, prio_q, wr_data};
    if (wr_vld) begin
      case (state_q)
        IDLE: start = wr_sop;
        RECV: begin
          if (wr_sop) begin
            drop_inc = 2'd1;
            start    = 1'b1;
          end else if (full) begin
            wptr_d     = cptr_q;
            overflow_d = 1'b1;
            drop_inc   = 2'd1;
            state_d    = wr_eop ? IDLE : DROP;
          end else begin
            we     = 1'b1;
            wptr_d = wptr_q + ptr_t'(1);
            if (wr_eop) begin
              commit  = 1'b1;
              cptr_d  = wptr_q + ptr_t'(1);
              state_d = IDLE;
            end
          end
        end
        DROP: begin
          if (wr_sop) start = 1'b1;
          else if (wr_eop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      // A new packet always starts at cptr: any partial packet has been rolled back.
      if (start) begin
        if (base_full) begin
          wptr_d     = cptr_q;
          overflow_d = 1'b1;
          drop_inc   = drop_inc + 2'd1;
          state_d    = wr_eop ? IDLE : DROP;
        end else begin
          we     = 1'b1;
          waddr  = cptr_q[ptr_width-1:0];
          wentry = {wr_sop, wr_eop, wr_prio, wr_data};
          prio_d = wr_prio;
          wptr_d = cptr_q + ptr_t'(1);
          if (wr_eop) begin
            commit  = 1'b1;
            cptr_d  = cptr_q + ptr_t'(1);
            state_d = IDLE;
          end else begin
            state_d = RECV;
          end
        end
      end
    end
  end

  always_comb begin
    rptr_d    = rd_fire ? rptr_q + ptr_t'(1) : rptr_q;
    pkt_cnt_d = pkt_cnt_q;
    case ({commit, rd_fire && rd_eop})
      2'b10:   pkt_cnt_d = pkt_cnt_q + ptr_t'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - ptr_t'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    free_d     = depth_p - (wptr_d - rptr_d);
    drop_sum   = {1'b0, drop_cnt_q} + (cnt_width+1)'(drop_inc);
    drop_cnt_d = drop_sum[cnt_width] ? '1 : drop_sum[cnt_width-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rptr_q     <= '0;
      cptr_q     <= '0;
      wptr_q     <= '0;
      prio_q     <= '0;
      pkt_cnt_q  <= '0;
      free_q     <= depth_p;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rptr_q     <= rptr_d;
      cptr_q     <= cptr_d;
      wptr_q     <= wptr_d;
      prio_q     <= prio_d;
      pkt_cnt_q  <= pkt_cnt_d;
      free_q     <= free_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[waddr] <= wentry;
  end

  assign pkt_cnt    = pkt_cnt_q;
  assign free_words = free_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: doc/pkt_fifo.md
Name: pkt_fifo

Overview:
- Single-clock, parametrised packet FIFO. Successor to the ingress word FIFO.
- Buffers sop/eop-framed words with a per-packet priority tag.
- Exposes only complete, committed packets to the reader.
- Drops whole packets on overflow or framing error, so a partial packet never reaches the SRAM controller.

Parameters:
data_width, 64, payload bits per word
depth, 512, storage words; must be a power of two
ptr_width, 9, log2(depth)
prio_width, 3, priority tag bits (8 priorities)
cnt_width, 16, drop counter width

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
wr_vld  in  1  write word valid
wr_sop  in  1  first word of packet, qualified by wr_vld
wr_eop  in  1  last word of packet, qualified by wr_vld
wr_data  in  data_width  write payload
wr_prio  in  prio_width  packet priority, sampled on the sop word
rd_en  in  1  consume the current read word
rd_vld  out  1  committed word available at the read head
rd_sop  out  1  sop flag of the head word
rd_eop  out  1  eop flag of the head word
rd_data  out  data_width  head word payload
rd_prio  out  prio_width  priority of the packet at the head
pkt_cnt  out  ptr_width+1  committed packets held
free_words  out  ptr_width+1  depth minus words held, including the uncommitted packet
overflow  out  1  sticky: at least one packet dropped because the FIFO was full
drop_cnt  out  cnt_width  packets dropped for any cause; saturates at all-ones

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- Pointers are ptr_width+1 bits wide with a wrap bit.
  - rptr: read pointer.
  - cptr: commit pointer.
  - wptr: working write pointer.
  - Words held = wptr - rptr. Full when this equals depth.
- Storage entry = {sop, eop, prio, data}. prio is the value latched at sop, written into every word of the packet.
- Memory is not cleared at reset. rd_sop, rd_eop, rd_data and rd_prio are don't-care while rd_vld=0.
- Reset values:
  - pointers 0; FSM IDLE; rd_vld 0; pkt_cnt 0
  - free_words = depth; overflow 0; drop_cnt 0
- Reset mid-packet discards the partial packet and all stored packets.
- Write FSM states: IDLE, RECV, DROP. A "word" below means a cycle with wr_vld=1.
  - IDLE, sop word:
    - If full: drop the packet (same action as the RECV full case).
    - Else write it and increment wptr.
    - If eop is also set, commit and stay in IDLE; otherwise go to RECV.
  - IDLE, word without sop: ignored; no counters change.
  - RECV, word without sop:
    - If full: wptr <= cptr, overflow <= 1, drop_cnt increments. Go to DROP, or to IDLE if this word has eop.
    - Else write it and increment wptr.
    - If eop: commit, i.e. cptr <= wptr+1, pkt_cnt increments, go to IDLE.
  - RECV, word with sop (framing error):
    - Drop the current packet: wptr <= cptr, drop_cnt increments.
    - The new word is then treated as an IDLE sop word in the same cycle, written at the old cptr.
  - DROP: discard all words. An eop word returns to IDLE. A sop word behaves as IDLE sop, with no additional drop.
- Full is evaluated with the rptr value before the current cycle's read. Space freed by a read is visible next cycle.
- Read side (first-word fall-through):
  - rd_vld = (rptr != cptr), derived from the registered cptr.
  - A packet is readable the cycle after its eop word is written.
  - rd_en && rd_vld: rptr increments; if rd_eop, pkt_cnt decrements.
  - rd_en while rd_vld=0 is ignored.
  - Read is never blocked by the write FSM state.
- Commit and read-eop in the same cycle: pkt_cnt is unchanged.
- Pointer wrap is natural modulo 2^(ptr_width+1). Data order is preserved across wrap.
- free_words and pkt_cnt are registered and reflect state after the previous edge.

Test Plan:
- Reset, then write a 4-word packet with prio=5 (data 0x11..0x44), rd_en=1 → rd_vld rises the cycle after eop. Read sees 0x11(sop)..0x44(eop), rd_prio=5 on all words; pkt_cnt goes 0→1→0; free_words returns to depth.
- Write 3 words with sop and no eop → rd_vld stays 0, free_words=depth-3, pkt_cnt=0.
- depth=8: commit a 5-word packet, then send a 6-word packet → its 4th word sees full. Result: free_words=3, overflow=1, drop_cnt=1, pkt_cnt=1; words 5–6 are discarded. A following 3-word packet is accepted, and reads return only the 5-word and 3-word packets.
- sop arrives after 2 words in RECV → drop_cnt=1. The new 2-word packet reads back intact; the aborted words never appear.
- depth=8: stream 20 3-word packets while reading continuously, with a last-eop read coinciding with a commit → pkt_cnt is unchanged on that cycle, all 60 words are in order across wrap, overflow=0.
- Assert rst mid-packet while pkt_cnt=2 → all outputs return to reset values; a subsequent 1-word sop+eop packet reads back correctly.
